// File: rtl/mul_pkg.sv
// mul_pkg: op and state encodings shared by the multiply unit
package mul_pkg;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULH = 2'b01, OP_MULHSU = 2'b10, OP_MULHU = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10} state_e;
endpackage

// File: rtl/mul_operand_prep.sv
// mul_operand_prep: operand magnitudes and product sign under RISC-V signedness rules
module mul_operand_prep
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic            neg
);
  logic neg1, neg2;
  assign neg1 = (op != OP_MULHU) && in1[XLEN-1];
  assign neg2 = (op == OP_MUL || op == OP_MULH) && in2[XLEN-1];
  // negating the most-negative value wraps to 2^(XLEN-1), which is its correct unsigned magnitude
  assign mag1 = neg1 ? -in1 : in1;
  assign mag2 = neg2 ? -in2 : in2;
  assign neg  = neg1 ^ neg2;
endmodule

// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiplier with valid/ready handshake
module mul_unit
  import mul_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_fix;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   mag1, mag2;
  logic              neg, zero;
  mul_operand_prep #(.XLEN(XLEN)) u_prep (
    .op  (op),
    .in1 (in1),
    .in2 (in2),
    .mag1(mag1),
    .mag2(mag2),
    .neg (neg)
  );
  assign zero      = ZERO_SKIP && (mag1 == '0 || mag2 == '0);
  assign prod_fix  = neg_q ? -prod_q : prod_q;
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign result    = result_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (in_valid) begin
        // a zero operand jumps the counter straight to the correction step on a zero product
        op_d     = op_e'(op);
        neg_d    = neg;
        mplier_d = mag2;
        mcand_d  = {{XLEN{1'b0}}, mag1};
        prod_d   = '0;
        cnt_d    = zero ? CW'(XLEN) : '0;
        state_d  = S_BUSY;
      end
      S_BUSY: if (cnt_q == CW'(XLEN)) begin
        prod_d   = prod_fix;
        result_d = op_q == OP_MUL ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end else begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule
